fetch_pc_ctrl: RTL and testbench

Fetch-stage sequencer for the 5-stage RISC-V pipeline. It owns the program counter and issues single-outstanding requests to instruction memory. It applies redirects from EX (branch/jump) and the trap unit, and honours hazard-unit stalls. Its output is a registered fetch slot (valid, PC, instruction) that feeds the IF/ID pipeline register, plus a flush pulse that squashes younger stages.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_slot.sv | 33 +++
 rtl/fetch_pc_ctrl.sv | 158 +++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// PC_MISALIGN_TRAP_EN adds the FAULT state used for misaligned branch targets.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    DRAIN = 3'd3
`ifdef PC_MISALIGN_TRAP_EN
    ,
    FAULT = 3'd4
`endif
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_slot.sv
// Registered fetch slot feeding IF/ID: load a response, hold while stalled,
// drop once consumed, and clear on any flush.
module fetch_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic        stall,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  // Clear outranks load so a response landing with a redirect is squashed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (!stall) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer with single-outstanding imem requests and redirects.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned branch targets fault instead of aligning.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        trap_i,
  input  logic [31:0] trap_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        flush_o,
  output logic        misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  target;
  logic         req;
  logic         redirect;
  logic         fault_evt;
  logic         outstanding;
  logic         slot_load;

  assign target      = trap_i ? trap_target_i : br_target_i;
  assign flush_o     = trap_i | br_taken_i;
  assign req         = (state_q == REQ) && !(if_valid_o && stall_i);
  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;

`ifdef PC_MISALIGN_TRAP_EN
  logic pend_q, pend_d;
  logic misalign_q;

  // Only a trap can leave FAULT; branches there merely flush.
  assign fault_evt  = !trap_i && br_taken_i && (state_q != FAULT) &&
                      (br_target_i[1:0] != 2'b00);
  assign redirect   = trap_i || (br_taken_i && (state_q != FAULT) && !fault_evt);
  assign misalign_o = misalign_q;

  always_comb begin
    pend_d = pend_q;
    if (fault_evt) begin
      pend_d = outstanding;
    end else if (state_q == FAULT) begin
      pend_d = pend_q && !imem_rvalid_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      misalign_q <= fault_evt;
    end
  end
`else
  assign fault_evt  = 1'b0;
  assign redirect   = flush_o;
  assign misalign_o = 1'b0;
`endif

  // Whether a response is still owed after this edge; decides DRAIN vs REQ on redirect.
  always_comb begin
    outstanding = 1'b0;
    case (state_q)
      REQ:         outstanding = req && imem_gnt_i;
      RESP, DRAIN: outstanding = !imem_rvalid_i;
`ifdef PC_MISALIGN_TRAP_EN
      FAULT:       outstanding = pend_q && !imem_rvalid_i;
`endif
      default:     outstanding = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    slot_load = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (req && imem_gnt_i) begin
          pc_d     = pc_q + 32'(INSTR_BYTES);
          req_pc_d = pc_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (imem_rvalid_i) begin
          slot_load = 1'b1;
          state_d   = REQ;
        end
      end
      DRAIN: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
        end
      end
      default: state_d = state_q;
    endcase

    // A redirect drops whatever response arrives this cycle.
    if (redirect) begin
      pc_d      = align_word(target);
      slot_load = 1'b0;
      state_d   = outstanding ? DRAIN : REQ;
`ifdef PC_MISALIGN_TRAP_EN
    end else if (fault_evt) begin
      pc_d      = pc_q;
      slot_load = 1'b0;
      state_d   = FAULT;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VECTOR;
      req_pc_q <= RESET_VECTOR;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (slot_load),
    .clear      (flush_o),
    .stall      (stall_i),
    .load_pc    (req_pc_q),
    .load_instr (imem_rdata_i),
    .valid      (if_valid_o),
    .pc         (if_pc_o),
    .instr      (if_instr_o)
  );

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a zero-wait instruction memory model.
// Expectations for the misaligned-branch step follow PC_MISALIGN_TRAP_EN.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, trap;
  logic [31:0] br_target, trap_target;
  logic        gnt_en, resp_en;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, flush, misalign;
  logic [31:0] if_pc, if_instr;
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .trap_i        (trap),
    .trap_target_i (trap_target),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt_en),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .if_valid_o    (if_valid),
    .if_pc_o       (if_pc),
    .if_instr_o    (if_instr),
    .flush_o       (flush),
    .misalign_o    (misalign)
  );

  // Memory answers one cycle after a grant unless resp_en holds it back.
  assign imem_rvalid = mem_pend && resp_en;
  assign imem_rdata  = {16'hC0DE, mem_addr[15:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_pend <= 1'b0;
      mem_addr <= 32'h0;
    end else begin
      if (imem_rvalid) mem_pend <= 1'b0;
      if (imem_req && gnt_en) begin
        mem_pend <= 1'b1;
        mem_addr <= imem_addr;
      end
    end
  end

  task automatic apply_stimulus(input logic s, input logic b, input logic [31:0] bt,
                                input logic t, input logic [31:0] tt);
    stall       = s;
    br_taken    = b;
    br_target   = bt;
    trap        = t;
    trap_target = tt;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    gnt_en  = 1'b1;
    resp_en = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_output("rst_valid", 32'(if_valid), 32'd0);
    check_output("rst_req", 32'(imem_req), 32'd0);
    check_output("rst_pc", if_pc, 32'h0);
    check_output("rst_instr", if_instr, 32'h0);
    check_output("rst_misalign", 32'(misalign), 32'd0);
    check_output("rst_addr", imem_addr, 32'h0);
    reset = 1'b0;

    @(negedge clk); #1;
    check_output("c1_req", 32'(imem_req), 32'd1);
    check_output("c1_addr", imem_addr, 32'h0);
    @(negedge clk); #1;
    check_output("c2_valid", 32'(if_valid), 32'd0);
    check_output("c2_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check_output("c3_valid", 32'(if_valid), 32'd1);
    check_output("c3_pc", if_pc, 32'h0);
    check_output("c3_instr", if_instr, 32'hC0DE_0000);
    check_output("c3_addr", imem_addr, 32'h4);

    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_output("stall_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_output("stall_valid", 32'(if_valid), 32'd1);
      check_output("stall_pc", if_pc, 32'h0);
      check_output("stall_instr", if_instr, 32'hC0DE_0000);
      check_output("stall_req_hold", 32'(imem_req), 32'd0);
    end
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_output("resume_req", 32'(imem_req), 32'd1);
    check_output("resume_addr", imem_addr, 32'h4);
    @(negedge clk); #1;
    check_output("c8_valid", 32'(if_valid), 32'd0);
    @(negedge clk); #1;
    check_output("c9_pc", if_pc, 32'h4);
    check_output("c9_instr", if_instr, 32'hC0DE_0004);
    check_output("c9_addr", imem_addr, 32'h8);

    // Branch while the response to 0x8 is held back.
    @(negedge clk);
    resp_en = 1'b0;
    apply_stimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    check_output("br_flush", 32'(flush), 32'd1);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_output("drain_flush", 32'(flush), 32'd0);
    check_output("drain_req", 32'(imem_req), 32'd0);
    check_output("drain_addr", imem_addr, 32'h100);
    @(negedge clk);
    resp_en = 1'b1;
    #1;
    check_output("drain_req2", 32'(imem_req), 32'd0);
    @(negedge clk); #1;
    check_output("stale_valid", 32'(if_valid), 32'd0);
    check_output("br_req", 32'(imem_req), 32'd1);
    check_output("br_addr", imem_addr, 32'h100);
    @(negedge clk);
    @(negedge clk);
    check_output("br_pc", if_pc, 32'h100);
    check_output("br_instr", if_instr, 32'hC0DE_0100);

    // Trap and branch together, with a stall that must not hold the slot.
    apply_stimulus(1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
    #1;
    check_output("trap_flush", 32'(flush), 32'd1);
    check_output("trap_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_output("trap_valid", 32'(if_valid), 32'd0);
    check_output("trap_addr", imem_addr, 32'h300);
    check_output("trap_req2", 32'(imem_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_output("trap_pc", if_pc, 32'h300);
    check_output("trap_instr", if_instr, 32'hC0DE_0300);

    // Redirect to the top word to exercise PC wraparound.
    apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    #1;
    check_output("wrap_flush", 32'(flush), 32'd1);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_output("wrap_drain_req", 32'(imem_req), 32'd0);
    check_output("wrap_drain_valid", 32'(if_valid), 32'd0);
    @(negedge clk); #1;
    check_output("wrap_req", 32'(imem_req), 32'd1);
    check_output("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check_output("wrap_next_addr", imem_addr, 32'h0);
    @(negedge clk);
    check_output("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check_output("wrap_instr", if_instr, 32'hC0DE_FFFC);

    // Misaligned branch target 0x102.
    apply_stimulus(1'b0, 1'b1, 32'h102, 1'b0, 32'h0);
    #1;
    check_output("mis_flush", 32'(flush), 32'd1);
`ifdef PC_MISALIGN_TRAP_EN
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_output("mis_pulse", 32'(misalign), 32'd1);
    check_output("mis_req", 32'(imem_req), 32'd0);
    check_output("mis_valid", 32'(if_valid), 32'd0);
    @(negedge clk); #1;
    check_output("mis_pulse_end", 32'(misalign), 32'd0);
    check_output("fault_req", 32'(imem_req), 32'd0);
    @(negedge clk); #1;
    check_output("fault_req2", 32'(imem_req), 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    #1;
    check_output("fault_trap_flush", 32'(flush), 32'd1);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_output("fault_exit_req", 32'(imem_req), 32'd1);
    check_output("fault_exit_addr", imem_addr, 32'h200);
    @(negedge clk);
    @(negedge clk);
    check_output("fault_exit_pc", if_pc, 32'h200);
    check_output("fault_exit_instr", if_instr, 32'hC0DE_0200);
`else
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check_output("mis_addr", imem_addr, 32'h100);
    check_output("mis_misalign", 32'(misalign), 32'd0);
    check_output("mis_req", 32'(imem_req), 32'd0);
    @(negedge clk); #1;
    check_output("mis_req2", 32'(imem_req), 32'd1);
    check_output("mis_addr2", imem_addr, 32'h100);
    check_output("mis_misalign2", 32'(misalign), 32'd0);
`endif

    // Asynchronous reset in the middle of operation.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("midrst_valid", 32'(if_valid), 32'd0);
    check_output("midrst_req", 32'(imem_req), 32'd0);
    check_output("midrst_addr", imem_addr, 32'h0);
    check_output("midrst_pc", if_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check_output("rerun_req", 32'(imem_req), 32'd1);
    check_output("rerun_addr", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
